// File: rtl/sensor_link_pkg.sv
// Shared definitions for the sensor polling link: responder state encoding,
// link-level constants and the CRC-8 helper used by both link ends.
package sensor_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_TURN      = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_SEND_CRC  = 3'd5,
        ST_WAIT_CRC  = 3'd6
    } state_e;

    localparam logic [2:0] ADDR_BCAST = 3'd0;
    localparam logic [7:0] CRC_POLY   = 8'h07;
    localparam logic [2:0] MAX_ADDR   = 3'd5;

    // CRC-8, poly 0x07, init 0x00, MSB first, no final XOR, over one byte.
    function automatic logic [7:0] crc8_calc(input logic [7:0] data);
        logic [7:0] crc;
        crc = data;
        for (int i = 0; i < 8; i++) begin
            if (crc[7]) begin
                crc = {crc[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/sensor_responder_if.sv
// Byte-level handshake between the responder and the node's UART core.
// The responder is the master: it consumes received bytes and issues writes.
interface sensor_responder_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_rdy_clr;
    logic [7:0] tx_data;
    logic       tx_wr_en;
    logic       tx_busy;

    modport master (
        input  rx_data, rx_rdy, tx_busy,
        output rx_rdy_clr, tx_data, tx_wr_en
    );

    modport slave (
        output rx_data, rx_rdy, tx_busy,
        input  rx_rdy_clr, tx_data, tx_wr_en
    );
endinterface

// File: rtl/crc8_byte.sv
// Combinational single-byte CRC-8 (link polynomial, see package helper).
module crc8_byte
    import sensor_link_pkg::*;
(
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_calc(data_in);

endmodule

// File: rtl/sensor_responder.sv
// Sensor-node responder: decodes one-byte polls and answers with a
// DATA + CRC frame (or an alarm frame while an alarm is latched).
// All outputs are registered; state and datapath use a synchronous reset.
module sensor_responder
    import sensor_link_pkg::*;
#(
    parameter logic [2:0]  NODE_ADDR  = 3'd1,
    parameter int unsigned TURNAROUND = 16,
    parameter logic [7:0]  ALARM_CODE = 8'hFF
) (
    input  logic               clock,
    input  logic               reset,
    sensor_responder_if.master uart,
    input  logic [7:0]         sensor_data,
    input  logic               alarm_in,
    output logic               alarm_pending,
    output logic               busy
);

    localparam logic [15:0] TURN_LAST = 16'(TURNAROUND - 1);

    state_e      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [7:0]  byte_r, data_r, crc_r;
    logic [7:0]  tx_data_r, strobe_byte_s;
    logic        rx_rdy_clr_r, rx_rdy_clr_s;
    logic        tx_wr_en_r, strobe_s;
    logic        capture_s, latch_s, ack_s;
    logic        alarm_r, busy_r;
    logic [7:0]  sensor_crc_s, alarm_crc_s;

    crc8_byte u_crc_sensor (.data_in(sensor_data), .crc_out(sensor_crc_s));
    crc8_byte u_crc_alarm  (.data_in(ALARM_CODE),  .crc_out(alarm_crc_s));

    // Next-state, byte-consumption and transmit-strobe decisions.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        capture_s     = 1'b0;
        latch_s       = 1'b0;
        ack_s         = 1'b0;
        strobe_s      = 1'b0;
        strobe_byte_s = 8'h00;
        // A held byte is consumed once; the registered clear masks the
        // cycle in which the receiver still shows the same byte.
        if (uart.rx_rdy && !rx_rdy_clr_r) begin
            rx_rdy_clr_s = 1'b1;
        end else begin
            rx_rdy_clr_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (rx_rdy_clr_s) begin
                    capture_s = 1'b1;
                    state_s   = ST_DECODE;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (byte_r[7:3] != 5'd0) begin
                    state_s = ST_IDLE;
                end else if (byte_r[2:0] == ADDR_BCAST) begin
                    ack_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (byte_r[2:0] == NODE_ADDR) begin
                    latch_s = 1'b1;
                    cnt_s   = 16'd0;
                    state_s = ST_TURN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (cnt_r == TURN_LAST) begin
                    state_s = ST_SEND_DATA;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                end
            end
            ST_SEND_DATA: begin
                if (!uart.tx_busy) begin
                    strobe_s      = 1'b1;
                    strobe_byte_s = data_r;
                    state_s       = ST_WAIT_DATA;
                end else begin
                    state_s       = ST_SEND_DATA;
                end
            end
            ST_WAIT_DATA: begin
                // The strobe cycle itself is skipped: tx_busy only rises after it.
                if (!tx_wr_en_r && !uart.tx_busy) begin
                    state_s = ST_SEND_CRC;
                end else begin
                    state_s = ST_WAIT_DATA;
                end
            end
            ST_SEND_CRC: begin
                if (!uart.tx_busy) begin
                    strobe_s      = 1'b1;
                    strobe_byte_s = crc_r;
                    state_s       = ST_WAIT_CRC;
                end else begin
                    state_s       = ST_SEND_CRC;
                end
            end
            ST_WAIT_CRC: begin
                if (!tx_wr_en_r && !uart.tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_CRC;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, alarm latch and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r        <= 16'd0;
            byte_r       <= 8'h00;
            data_r       <= 8'h00;
            crc_r        <= 8'h00;
            tx_data_r    <= 8'h00;
            tx_wr_en_r   <= 1'b0;
            rx_rdy_clr_r <= 1'b0;
            alarm_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            rx_rdy_clr_r <= rx_rdy_clr_s;
            tx_wr_en_r   <= strobe_s;
            busy_r       <= (state_s != ST_IDLE);
            if (capture_s) begin
                byte_r <= uart.rx_data;
            end
            // Frame contents are frozen at decode so later sensor changes
            // cannot corrupt the frame in flight.
            if (latch_s) begin
                if (alarm_r) begin
                    data_r <= ALARM_CODE;
                    crc_r  <= ~alarm_crc_s;
                end else begin
                    data_r <= sensor_data;
                    crc_r  <= sensor_crc_s;
                end
            end
            if (strobe_s) begin
                tx_data_r <= strobe_byte_s;
            end
            // A new alarm takes priority over an acknowledge in the same cycle.
            if (alarm_in) begin
                alarm_r <= 1'b1;
            end else if (ack_s) begin
                alarm_r <= 1'b0;
            end
        end
    end

    assign uart.rx_rdy_clr = rx_rdy_clr_r;
    assign uart.tx_data    = tx_data_r;
    assign uart.tx_wr_en   = tx_wr_en_r;
    assign alarm_pending   = alarm_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_sensor_responder.sv
// Directed bench for sensor_responder with a small UART-side model.
module tb_sensor_responder;

    logic       clock;
    logic       reset;
    logic [7:0] sensor_data;
    logic       alarm_in;
    logic       alarm_pending;
    logic       busy;
    logic       hold_busy;

    sensor_responder_if ifc ();

    sensor_responder #(
        .NODE_ADDR  (3'd1),
        .TURNAROUND (16),
        .ALARM_CODE (8'hFF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .uart          (ifc),
        .sensor_data   (sensor_data),
        .alarm_in      (alarm_in),
        .alarm_pending (alarm_pending),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int viol_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] txq[$];

    // Transmitter model: records strobes, goes busy the cycle after a write.
    always @(posedge clock) begin
        if (ifc.tx_wr_en) begin
            txq.push_back(ifc.tx_data);
        end
        if (ifc.tx_wr_en && ifc.tx_busy) begin
            viol_cnt <= viol_cnt + 1;
        end
        if (reset) begin
            busy_cnt <= 0;
        end else if (ifc.tx_wr_en) begin
            busy_cnt <= 3;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign ifc.tx_busy = hold_busy | (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_poll(input string tag, input logic [7:0] b);
        logic got;
        got = 1'b0;
        @(negedge clock);
        ifc.rx_data = b;
        ifc.rx_rdy  = 1'b1;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clock);
            if (ifc.rx_rdy_clr) begin
                got = 1'b1;
                ifc.rx_rdy = 1'b0;
            end
        end
        ifc.rx_rdy = 1'b0;
        chk({tag, "_clr"}, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clock);
            if (!busy) begin
                idle = 1'b1;
            end
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_frame(input string tag, input int n0,
                                input logic [7:0] d, input logic [7:0] c);
        chk({tag, "_count"}, 32'(txq.size()), 32'(n0 + 2));
        chk({tag, "_data"},  32'(txq[n0]),     32'(d));
        chk({tag, "_crc"},   32'(txq[n0 + 1]), 32'(c));
    endtask

    initial begin
        int  n0;
        int  lat;
        logic seen;

        reset       = 1'b1;
        sensor_data = 8'h00;
        alarm_in    = 1'b0;
        hold_busy   = 1'b0;
        ifc.rx_data = 8'h00;
        ifc.rx_rdy  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_rx_rdy_clr", 32'(ifc.rx_rdy_clr), 32'd0);
        chk("rst_tx_wr_en",   32'(ifc.tx_wr_en),   32'd0);
        chk("rst_tx_data",    32'(ifc.tx_data),    32'd0);
        chk("rst_alarm",      32'(alarm_pending),  32'd0);
        chk("rst_busy",       32'(busy),           32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Normal frame, latency and sensor sampling only at decode.
        sensor_data = 8'h80;
        n0  = txq.size();
        lat = 0;
        @(negedge clock);
        ifc.rx_data = 8'h01;
        ifc.rx_rdy  = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clock);
            if (ifc.rx_rdy_clr) begin
                ifc.rx_rdy = 1'b0;
            end
            if (k == 2) begin
                sensor_data = 8'h55;
            end
            if (ifc.tx_wr_en) begin
                lat = k;
            end
        end
        ifc.rx_rdy = 1'b0;
        chk("latency", 32'(lat), 32'd19);
        wait_idle("f80");
        expect_frame("f80", n0, 8'h80, 8'h89);
        chk("tx_data_hold", 32'(ifc.tx_data), 32'h89);

        // Second sensor value.
        sensor_data = 8'h01;
        n0 = txq.size();
        send_poll("p01", 8'h01);
        wait_idle("f01");
        expect_frame("f01", n0, 8'h01, 8'h07);

        // Other node's address: consumed, no response.
        n0 = txq.size();
        send_poll("p02", 8'h02);
        repeat (40) @(negedge clock);
        chk("p02_no_tx", 32'(txq.size()), 32'(n0));

        // Alarm frame, acknowledge, then normal frame.
        @(negedge clock);
        alarm_in = 1'b1;
        @(negedge clock);
        alarm_in = 1'b0;
        chk("alarm_set", 32'(alarm_pending), 32'd1);
        n0 = txq.size();
        send_poll("palm", 8'h01);
        wait_idle("falm");
        expect_frame("falm", n0, 8'hFF, 8'h0C);
        chk("alarm_kept", 32'(alarm_pending), 32'd1);
        n0 = txq.size();
        send_poll("pack", 8'h00);
        wait_idle("fack");
        repeat (20) @(negedge clock);
        chk("alarm_clr", 32'(alarm_pending), 32'd0);
        chk("ack_no_tx", 32'(txq.size()), 32'(n0));
        sensor_data = 8'h80;
        n0 = txq.size();
        send_poll("pnrm", 8'h01);
        wait_idle("fnrm");
        expect_frame("fnrm", n0, 8'h80, 8'h89);

        // Alarm held during acknowledge: set wins.
        alarm_in = 1'b1;
        send_poll("pset", 8'h00);
        wait_idle("fset");
        alarm_in = 1'b0;
        chk("set_wins", 32'(alarm_pending), 32'd1);
        send_poll("pclr", 8'h00);
        wait_idle("fclr");
        chk("alarm_clr2", 32'(alarm_pending), 32'd0);

        // Transmitter busy at DATA time, extra poll during WAIT_DATA.
        sensor_data = 8'h01;
        hold_busy   = 1'b1;
        n0 = txq.size();
        send_poll("pbsy", 8'h01);
        repeat (100) @(negedge clock);
        chk("bsy_no_tx", 32'(txq.size()), 32'(n0));
        chk("bsy_busy",  32'(busy), 32'd1);
        hold_busy = 1'b0;
        @(negedge clock);
        chk("bsy_strobe", 32'(ifc.tx_wr_en), 32'd1);
        send_poll("pdup", 8'h01);
        wait_idle("fbsy");
        repeat (40) @(negedge clock);
        expect_frame("fbsy", n0, 8'h01, 8'h07);

        // Reset in WAIT_DATA aborts the (alarm) frame.
        @(negedge clock);
        alarm_in = 1'b1;
        @(negedge clock);
        alarm_in = 1'b0;
        n0   = txq.size();
        seen = 1'b0;
        send_poll("prst", 8'h01);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (ifc.tx_wr_en) begin
                seen = 1'b1;
            end
        end
        chk("rst_first_strobe", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_tx_wr_en", 32'(ifc.tx_wr_en),   32'd0);
        chk("mid_rst_tx_data",  32'(ifc.tx_data),    32'd0);
        chk("mid_rst_busy",     32'(busy),           32'd0);
        chk("mid_rst_alarm",    32'(alarm_pending),  32'd0);
        chk("mid_rst_clr",      32'(ifc.rx_rdy_clr), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("rst_aborted", 32'(txq.size()), 32'(n0 + 1));
        chk("rst_alarm_byte", 32'(txq[n0]), 32'hFF);
        sensor_data = 8'h80;
        n0 = txq.size();
        send_poll("pfresh", 8'h01);
        wait_idle("ffresh");
        expect_frame("ffresh", n0, 8'h80, 8'h89);

        // Upper address bits set: ignored.
        n0 = txq.size();
        send_poll("p09", 8'h09);
        repeat (40) @(negedge clock);
        chk("p09_no_tx", 32'(txq.size()), 32'(n0));
        chk("p09_busy",  32'(busy), 32'd0);

        chk("no_wr_while_busy", 32'(viol_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_responder.md
# sensor_responder

Sensor-node end of the UART polling link. It decodes the one-byte poll from the bus master, and when the poll carries this node's address it answers with a two-byte frame: a DATA byte followed by a CRC-8 byte. A latched alarm replaces the normal frame with an alarm frame, and address 0 acknowledges and clears the alarm. The block sits between the node's byte-level UART core and its sensor sampling logic.

## Interface
- NODE_ADDR, 3'd1: this node's address; legal range 1..5.
- TURNAROUND, 16: idle cycles between poll decode and the DATA write. Minimum 1.
- ALARM_CODE, 8'hFF: DATA byte of the alarm frame.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  byte from the UART receiver.
- rx_rdy  in  1  receiver holds a byte.
- rx_rdy_clr  out  1  one-cycle pulse that consumes the held byte.
- tx_data  out  8  byte to the UART transmitter.
- tx_wr_en  out  1  one-cycle write strobe.
- tx_busy  in  1  transmitter busy; asserted the cycle after tx_wr_en.
- sensor_data  in  8  current sensor reading.
- alarm_in  in  1  alarm event; level or pulse, sampled every cycle.
- alarm_pending  out  1  alarm is latched and not yet acknowledged.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DECODE, TURN, SEND_DATA, WAIT_DATA, SEND_CRC, WAIT_CRC.
- Byte consumption: whenever rx_rdy=1, the block pulses rx_rdy_clr for one cycle and captures rx_data, but only in IDLE. Bytes arriving in any other state are consumed and discarded.
- IDLE → DECODE on a captured byte.
- Decode of byte b:
  - b[7:3]≠0: ignore, return to IDLE.
  - b[2:0]=0: clear alarm_pending, return to IDLE, no response.
  - b[2:0]≠NODE_ADDR: return to IDLE.
  - b[2:0]=NODE_ADDR: go to TURN and latch the frame.
- Frame latch:
  - If alarm_pending=1: data=ALARM_CODE, crc=~crc8(ALARM_CODE).
  - Else: data=sensor_data, crc=crc8(sensor_data).
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB first, no final XOR.
- TURN: counts TURNAROUND cycles, then → SEND_DATA.
- SEND_DATA: waits for tx_busy=0, then drives tx_data=data with tx_wr_en=1 for one cycle → WAIT_DATA.
- WAIT_DATA: skips one cycle, then waits for tx_busy=0 → SEND_CRC.
- SEND_CRC and WAIT_CRC behave the same way with the crc byte; WAIT_CRC exits to IDLE.
- Alarm latch: alarm_in=1 sets alarm_pending. Only an address-0 poll or reset clears it.
  - Set and clear in the same cycle: set wins.
  - alarm_pending stays set after an alarm frame is sent; the master must acknowledge with address 0.

## Timing
- Reset values: rx_rdy_clr=0, tx_wr_en=0, tx_data=0, alarm_pending=0, busy=0, state=IDLE.
- Reset mid-frame aborts the frame; no further tx_wr_en is issued.
- Poll byte to DATA strobe with tx_busy low: 1 (capture) + 1 (DECODE) + TURNAROUND + 1 cycles.
- tx_wr_en is never asserted while tx_busy=1. There are exactly two strobes per frame.
- sensor_data is sampled in the DECODE cycle only; later changes do not affect the frame in flight.
- tx_data holds its value from the strobe until the next strobe.

## Structure
- Shared package `sensor_link_pkg`: the state encoding, ADDR_BCAST=3'd0, CRC_POLY=8'h07, MAX_ADDR=3'd5. The master-side CRC checker also uses this package.
- Sub-module `crc8_byte`: combinational, 8-bit in, 8-bit CRC out. One instance on sensor_data, one on ALARM_CODE.
- Estimated size: ~200 lines of RTL.

## Test plan
- NODE_ADDR=1, poll 8'h01, sensor_data=8'h80 → tx bytes 8'h80 then 8'h89; busy returns to 0.
- Poll 8'h01 with sensor_data=8'h01 → 8'h01, 8'h07. Poll 8'h02 → no tx_wr_en; rx_rdy_clr still pulses.
- Pulse alarm_in, then poll 8'h01 → 8'hFF, 8'h0C; alarm_pending stays 1. Poll 8'h00 → alarm_pending=0, no tx. A following 8'h01 poll yields a normal frame.
- Hold tx_busy=1 for 100 cycles at DATA time → strobe occurs the cycle after tx_busy falls. A second poll byte during WAIT_DATA is consumed, discarded, and does not cause a second frame.
- Assert reset in WAIT_DATA → all outputs return to reset values; a fresh poll yields a complete, correct frame.
- Poll 8'h09 (upper bits set) → ignored, no tx.
